instr_encoder: RTL and testbench

//  Inverse of the opcode decoder: packs a control bundle (mem_read, mem_write, wb_en,
//  is_immediate, br, execute command) plus register/immediate fields back into a 32-bit

---
 rtl/instr_encoder_if.sv | 36 +++
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
`timescale 1ns/1ps
// Handshake bundle between the instruction encoder and its producer/consumer.
// The slave modport is the encoder's view; the master modport is the driver's view.
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mem_read;
    logic              in_mem_write;
    logic              in_wb_en;
    logic              in_is_imm;
    logic [1:0]        in_br;
    logic [3:0]        in_exe_cmd;
    logic              in_sla;
    logic [4:0]        in_dest;
    logic [4:0]        in_src1;
    logic [15:0]       in_src2_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    modport master (
        output in_valid, in_mem_read, in_mem_write, in_wb_en, in_is_imm, in_br,
               in_exe_cmd, in_sla, in_dest, in_src1, in_src2_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err
    );

    modport slave (
        input  in_valid, in_mem_read, in_mem_write, in_wb_en, in_is_imm, in_br,
               in_exe_cmd, in_sla, in_dest, in_src1, in_src2_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err
    );
endinterface

// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
// Packs a decoded control bundle back into a 32-bit instruction word and streams it out
// of a small FIFO with a running byte address. Define ENCODER_ILLEGAL_TRAP_EN to drop
// illegal bundles and pulse err instead of pushing a NOP word.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_STEP = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             flush,
    instr_encoder_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [5:0]        enc_op;
    logic              enc_legal;
    logic [15:0]       enc_low16;
    logic [31:0]       enc_word;
    logic              no_mem;

    logic [31:0]       mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [ADDR_W-1:0] addr_q;
    logic              full;
    logic              empty;
    logic              in_ready_int;
    logic              accept;
    logic              push;
    logic              pop;

    assign no_mem = !bus.in_mem_read && !bus.in_mem_write;

    always_comb begin
        enc_op    = 6'b000000;
        enc_legal = 1'b0;
        if (no_mem && !bus.in_wb_en && !bus.in_is_imm && bus.in_br == 2'b00
                && bus.in_exe_cmd == 4'b0000) begin
            enc_legal = 1'b1;
        end else if (no_mem && bus.in_wb_en && !bus.in_is_imm && bus.in_br == 2'b00) begin
            enc_legal = 1'b1;
            case (bus.in_exe_cmd)
                4'b0000: enc_op = 6'b000001;
                4'b0010: enc_op = 6'b000011;
                4'b0100: enc_op = 6'b000101;
                4'b0101: enc_op = 6'b000110;
                4'b0110: enc_op = 6'b000111;
                4'b0111: enc_op = 6'b001000;
                4'b1000: enc_op = bus.in_sla ? 6'b001001 : 6'b001010;
                4'b1001: enc_op = 6'b001011;
                4'b1010: enc_op = 6'b001100;
                default: enc_legal = 1'b0;
            endcase
        end else if (no_mem && bus.in_wb_en && bus.in_is_imm && bus.in_br == 2'b00) begin
            enc_legal = 1'b1;
            case (bus.in_exe_cmd)
                4'b0000: enc_op = 6'b100000;
                4'b0010: enc_op = 6'b100001;
                default: enc_legal = 1'b0;
            endcase
        end else if (bus.in_mem_read && !bus.in_mem_write && bus.in_wb_en && bus.in_is_imm
                && bus.in_br == 2'b00 && bus.in_exe_cmd == 4'b0000) begin
            enc_legal = 1'b1;
            enc_op    = 6'b100100;
        end else if (bus.in_mem_write && !bus.in_mem_read && !bus.in_wb_en && bus.in_is_imm
                && bus.in_br == 2'b00 && bus.in_exe_cmd == 4'b0000) begin
            enc_legal = 1'b1;
            enc_op    = 6'b100101;
        end else if (no_mem && !bus.in_wb_en && bus.in_is_imm && bus.in_br != 2'b00
                && bus.in_exe_cmd == 4'b0000) begin
            enc_legal = 1'b1;
            case (bus.in_br)
                2'b01:   enc_op = 6'b101000;
                2'b10:   enc_op = 6'b101001;
                default: enc_op = 6'b101010;
            endcase
        end
    end

    assign enc_low16 = bus.in_is_imm ? bus.in_src2_imm : {bus.in_src2_imm[4:0], 11'b0};
    // NOP and illegal bundles both carry op 0; the whole word is zeroed, fields included.
    assign enc_word  = (enc_legal && enc_op != 6'b000000)
                     ? {enc_op, bus.in_dest, bus.in_src1, enc_low16} : 32'h0;

    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W])
                       && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_ready_int = !full && !flush;
    assign accept       = bus.in_valid && in_ready_int;
    assign pop          = !empty && bus.out_ready && !flush;

`ifdef ENCODER_ILLEGAL_TRAP_EN
    logic err_q;

    assign push = accept && enc_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !enc_legal;
        end
    end

    assign bus.err = err_q;
`else
    assign push    = accept;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr_q <= ADDR_W'(BASE_ADDR);
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr_q <= ADDR_W'(BASE_ADDR);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= addr_q + ADDR_W'(ADDR_STEP);
            end
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= enc_word;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? 32'h0 : mem[rd_ptr[PTR_W-1:0]];
    assign bus.out_addr  = addr_q;
endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
// Table-driven bench for instr_encoder with a scoreboard queue checked at the output side,
// plus hand sequences for latency, backpressure, flush, reset and address wrap.
module tb_instr_encoder;
`ifdef ENCODER_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic flush4 = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(32)) bus ();
    instr_encoder_if #(.ADDR_W(4))  bus4 ();

    instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(0), .ADDR_STEP(4)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );
    instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(0), .ADDR_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush4), .bus(bus4)
    );

    typedef struct {
        logic        rd, wr, wb, imm;
        logic [1:0]  br;
        logic [3:0]  exe;
        logic        sla;
        logic [4:0]  dest, src1;
        logic [15:0] s2i;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t        vecs [23];
    logic [31:0] sb [$];
    logic [31:0] exp_addr = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic vec_t mkv(input logic rd, wr, wb, imm, input logic [1:0] br,
                                 input logic [3:0] exe, input logic sla,
                                 input logic [4:0] dest, src1, input logic [15:0] s2i,
                                 input logic legal, input logic [31:0] word);
        vec_t v;
        v.rd = rd; v.wr = wr; v.wb = wb; v.imm = imm; v.br = br; v.exe = exe; v.sla = sla;
        v.dest = dest; v.src1 = src1; v.s2i = s2i; v.legal = legal; v.word = word;
        return v;
    endfunction

    function automatic logic [31:0] w(input logic [5:0] op, input logic [4:0] d, s,
                                      input logic [15:0] low);
        return {op, d, s, low};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_mem_read  = v.rd;
        bus.in_mem_write = v.wr;
        bus.in_wb_en     = v.wb;
        bus.in_is_imm    = v.imm;
        bus.in_br        = v.br;
        bus.in_exe_cmd   = v.exe;
        bus.in_sla       = v.sla;
        bus.in_dest      = v.dest;
        bus.in_src1      = v.src1;
        bus.in_src2_imm  = v.s2i;
    endtask

    task automatic send(input vec_t v);
        int budget = 0;
        @(negedge clk);
        drive(v);
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && budget < 100) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1");
            bus.in_valid = 1'b0;
            return;
        end
        if (v.legal || !TRAP) sb.push_back(v.word);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("drain_queue_size", 32'(sb.size()), 32'd0);
        @(negedge clk);
        #3;
        check("drained_out_valid", {31'b0, bus.out_valid}, 32'd0);
    endtask

    // Output-side scoreboard: a pop happens at the next edge when valid&&ready and no flush.
    always @(negedge clk) begin
        #2;
        if (!rst && !flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %h, expected no output", bus.out_instr);
            end else begin
                check("pop_instr", bus.out_instr, sb[0]);
                check("pop_addr", bus.out_addr, exp_addr);
                void'(sb.pop_front());
                exp_addr = exp_addr + 32'd4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(0,0,1,0,2'b00,4'h0,0, 5'd3, 5'd1, 16'h0002, 1, 32'h04611000);
        vecs[1]  = mkv(0,0,1,0,2'b00,4'h2,0, 5'd7, 5'd8, 16'hFFE3, 1, w(6'b000011,5'd7,5'd8,16'h1800));
        vecs[2]  = mkv(0,0,1,0,2'b00,4'h4,0, 5'd1, 5'd2, 16'h0004, 1, w(6'b000101,5'd1,5'd2,16'h2000));
        vecs[3]  = mkv(0,0,1,0,2'b00,4'h5,0, 5'd2, 5'd3, 16'h0005, 1, w(6'b000110,5'd2,5'd3,16'h2800));
        vecs[4]  = mkv(0,0,1,0,2'b00,4'h6,0, 5'd4, 5'd5, 16'h0006, 1, w(6'b000111,5'd4,5'd5,16'h3000));
        vecs[5]  = mkv(0,0,1,0,2'b00,4'h7,0, 5'd6, 5'd7, 16'h0007, 1, w(6'b001000,5'd6,5'd7,16'h3800));
        vecs[6]  = mkv(0,0,1,0,2'b00,4'h8,1, 5'd8, 5'd9, 16'h0008, 1, w(6'b001001,5'd8,5'd9,16'h4000));
        vecs[7]  = mkv(0,0,1,0,2'b00,4'h8,0, 5'd10,5'd11,16'h0009, 1, w(6'b001010,5'd10,5'd11,16'h4800));
        vecs[8]  = mkv(0,0,1,0,2'b00,4'h9,0, 5'd12,5'd13,16'h000A, 1, w(6'b001011,5'd12,5'd13,16'h5000));
        vecs[9]  = mkv(0,0,1,0,2'b00,4'hA,0, 5'd31,5'd30,16'h001F, 1, w(6'b001100,5'd31,5'd30,16'hF800));
        vecs[10] = mkv(0,0,1,1,2'b00,4'h0,0, 5'd1, 5'd2, 16'h1234, 1, w(6'b100000,5'd1,5'd2,16'h1234));
        vecs[11] = mkv(0,0,1,1,2'b00,4'h2,0, 5'd3, 5'd4, 16'hABCD, 1, w(6'b100001,5'd3,5'd4,16'hABCD));
        vecs[12] = mkv(1,0,1,1,2'b00,4'h0,0, 5'd5, 5'd0, 16'h0010, 1, 32'h90A00010);
        vecs[13] = mkv(0,1,0,1,2'b00,4'h0,0, 5'd6, 5'd7, 16'h8000, 1, w(6'b100101,5'd6,5'd7,16'h8000));
        vecs[14] = mkv(0,0,0,1,2'b01,4'h0,0, 5'd0, 5'd1, 16'h0008, 1, w(6'b101000,5'd0,5'd1,16'h0008));
        vecs[15] = mkv(0,0,0,1,2'b10,4'h0,0, 5'd0, 5'd2, 16'hFFFC, 1, 32'hA402FFFC);
        vecs[16] = mkv(0,0,0,1,2'b11,4'h0,0, 5'd0, 5'd0, 16'h0100, 1, w(6'b101010,5'd0,5'd0,16'h0100));
        vecs[17] = mkv(0,0,0,0,2'b00,4'h0,0, 5'd5, 5'd6, 16'h1234, 1, 32'h0);
        vecs[18] = mkv(1,1,0,0,2'b00,4'h0,0, 5'd1, 5'd1, 16'h0001, 0, 32'h0);
        vecs[19] = mkv(0,0,1,0,2'b00,4'h1,0, 5'd1, 5'd1, 16'h0001, 0, 32'h0);
        vecs[20] = mkv(0,0,1,1,2'b00,4'h4,0, 5'd1, 5'd1, 16'h0001, 0, 32'h0);
        vecs[21] = mkv(0,0,1,1,2'b10,4'h0,0, 5'd0, 5'd2, 16'h0004, 0, 32'h0);
        vecs[22] = mkv(1,1,1,1,2'b00,4'h0,0, 5'd2, 5'd3, 16'h0004, 0, 32'h0);

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(vecs[17]);
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        bus4.in_mem_read = 1'b0; bus4.in_mem_write = 1'b0; bus4.in_wb_en = 1'b1;
        bus4.in_is_imm = 1'b0; bus4.in_br = 2'b00; bus4.in_exe_cmd = 4'h0; bus4.in_sla = 1'b0;
        bus4.in_dest = 5'd3; bus4.in_src1 = 5'd1; bus4.in_src2_imm = 16'h0002;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_addr", bus.out_addr, 32'h0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // table: every encoding, streamed back-to-back
        foreach (vecs[i]) send(vecs[i]);
        idle();
        wait_drain();

        // latency and no bypass: LD then BNE
        @(negedge clk);
        drive(vecs[12]);
        bus.in_valid = 1'b1;
        #1;
        check("no_bypass_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("empty_in_ready", {31'b0, bus.in_ready}, 32'd1);
        sb.push_back(32'h90A00010);
        @(posedge clk);
        #1;
        check("latency1_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("latency1_instr", bus.out_instr, 32'h90A00010);
        send(vecs[15]);
        idle();
        wait_drain();

        // illegal mem_read&mem_write
        send(vecs[18]);
        #1;
        check("illegal_err", {31'b0, bus.err}, {31'b0, TRAP});
        check("illegal_out_valid", {31'b0, bus.out_valid}, {31'b0, !TRAP});
        idle();
        @(posedge clk);
        #1;
        check("err_one_cycle", {31'b0, bus.err}, 32'd0);
        wait_drain();

        // backpressure: four fill the FIFO, the fifth is held until a pop
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(vecs[i]);
        @(negedge clk);
        drive(vecs[4]);
        bus.in_valid = 1'b1;
        #1;
        check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("held_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        send(vecs[4]);
        idle();
        wait_drain();

        // flush with three queued and a push in the flush cycle
        bus.out_ready = 1'b0;
        for (int i = 5; i < 8; i++) send(vecs[i]);
        @(negedge clk);
        drive(vecs[8]);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("preflush_addr_nonzero", {31'b0, bus.out_addr != 32'h0}, 32'd1);
        @(posedge clk);
        #1;
        sb.delete();
        exp_addr = 32'h0;
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("flush_out_addr", bus.out_addr, 32'h0);
        check("flush_err", {31'b0, bus.err}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_push_dropped", {31'b0, bus.out_valid}, 32'd0);

        // asynchronous reset in the middle of a push
        bus.out_ready = 1'b1;
        send(vecs[0]);
        send(vecs[1]);
        idle();
        wait_drain();
        bus.out_ready = 1'b0;
        send(vecs[2]);
        @(negedge clk);
        drive(vecs[3]);
        bus.in_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_rst_out_addr", bus.out_addr, 32'h0);
        check("async_rst_out_instr", bus.out_instr, 32'h0);
        check("async_rst_err", {31'b0, bus.err}, 32'd0);
        sb.delete();
        exp_addr = 32'h0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_empty", {31'b0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        send(vecs[0]);
        idle();
        wait_drain();

        // 4-bit address wraps after the fourth pop
        for (int i = 0; i < 5; i++) begin
            logic [3:0] ea;
            ea = 4'(i * 4);
            @(negedge clk);
            bus4.in_valid = 1'b1;
            @(negedge clk);
            bus4.in_valid = 1'b0;
            #1;
            check("wrap_out_valid", {31'b0, bus4.out_valid}, 32'd1);
            check("wrap_out_addr", {28'b0, bus4.out_addr}, {28'b0, ea});
            check("wrap_out_instr", bus4.out_instr, 32'h04611000);
            bus4.out_ready = 1'b1;
            @(negedge clk);
            bus4.out_ready = 1'b0;
        end
        #1;
        check("wrap_drained", {31'b0, bus4.out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
